// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: word width, bubble word,
// reset PC, fetch-FSM state encoding and the IF/ID payload layout.
// No logic of its own; imported by every file of the fetch stage.
package fetch_unit_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_3000;

    // Fetch FSM encoding kept as plain constants so older tools can read it.
    localparam logic [1:0] ST_FETCH = 2'd0;   // request outstanding
    localparam logic [1:0] ST_DROP  = 2'd1;   // stale request outstanding
    localparam logic [1:0] ST_HOLD  = 2'd2;   // word parked in buffer during stall

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic              vld;
    } ifid_t;

    // Instruction memory is word addressed: low two bits are always cleared.
    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
// Latency: none (wires only).
// Backpressure: imem acks one cycle per accepted request, any number of cycles later.
// Signals: imemReq/imemAddr (fetch -> mem), imemAck/imemData (mem -> fetch).
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imemReq;
    logic [WORD_W-1:0] imemAddr;
    logic              imemAck;
    logic [WORD_W-1:0] imemData;

    modport master (output imemReq, output imemAddr, input imemAck, input imemData);
    modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// Pipeline register carrying {pc, instr, valid} between two stages.
// Latency: 1 cycle from load to output.
// Backpressure: hold_i freezes contents; squash_i wins over load and hold.
// Ports: clk/rst, load_i/squash_i/hold_i controls, pc_i/instr_i in, pc_o/instr_o/vld_o out.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              squash_i,
    input  logic              hold_i,
    input  logic [WORD_W-1:0] pc_i,
    input  logic [WORD_W-1:0] instr_i,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] instr_o,
    output logic              vld_o
);

    ifid_t stage_q, stage_d;

    // With no control asserted the stage fills with a bubble.
    always_comb begin
        stage_d = '{pc: pc_i, instr: NOP_WORD, vld: 1'b0};
        if (!squash_i) begin
            if (load_i) begin
                stage_d = '{pc: pc_i, instr: instr_i, vld: 1'b1};
            end else if (hold_i) begin
                stage_d = stage_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '{pc: '0, instr: NOP_WORD, vld: 1'b0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign pc_o    = stage_q.pc;
    assign instr_o = stage_q.instr;
    assign vld_o   = stage_q.vld;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, runs the imem req/ack handshake, feeds IF/ID.
// Latency: 1 instruction per cycle with zero-wait memory; fetch-to-ID is 1 cycle.
// Backpressure: stall holds PC and IF/ID; a word acked under stall is parked in HOLD.
// Ports: clk/reset, newPC/flushID/flushEX/stall from next-PC/hazard logic,
//   imem (fetch_unit_if master), pc/instruction/fetchValid to next-PC logic,
//   pcID/instrID/validID from the IF/ID register.
// Build option FETCH_STATS_EN adds fetchWaitCount and squashCount outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] newPC,
    input  logic              flushID,
    input  logic              flushEX,
    input  logic              stall,
    fetch_unit_if.master      imem,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] instruction,
    output logic              fetchValid,
    output logic [WORD_W-1:0] pcID,
    output logic [WORD_W-1:0] instrID,
    output logic              validID
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       fetchWaitCount,
    output logic [31:0]       squashCount
`endif
);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              id_load, id_squash, id_hold;
    logic [WORD_W-1:0] id_instr;
    logic [WORD_W-1:0] next_pc;
    logic              ack;

    // flushEX belongs to later stages; newPC low bits are dropped by alignment.
    logic unused_ok;
    assign unused_ok = ^{flushEX, newPC[1:0]};

    assign next_pc = align_pc(newPC);
    assign ack     = imem.imemAck;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        id_load   = 1'b0;
        id_squash = 1'b0;
        id_hold   = 1'b0;
        id_instr  = imem.imemData;
        case (state_q)
            ST_FETCH: begin
                if (ack) begin
                    if (flushID) begin
                        // request already completed, so no DROP needed
                        id_squash = 1'b1;
                        pc_d      = next_pc;
                    end else if (stall) begin
                        buf_d   = imem.imemData;
                        state_d = ST_HOLD;
                        id_hold = 1'b1;
                    end else begin
                        id_load = 1'b1;
                        pc_d    = next_pc;
                    end
                end else if (flushID) begin
                    pc_d      = next_pc;
                    state_d   = ST_DROP;
                    id_squash = 1'b1;
                end else if (stall) begin
                    id_hold = 1'b1;
                end else begin
                    id_squash = 1'b1;
                end
            end
            ST_DROP: begin
                id_squash = 1'b1;
                if (flushID) pc_d = next_pc;
                if (ack) state_d = ST_FETCH;
            end
            ST_HOLD: begin
                if (flushID) begin
                    pc_d      = next_pc;
                    id_squash = 1'b1;
                    state_d   = ST_FETCH;
                end else if (stall) begin
                    id_hold = 1'b1;
                end else begin
                    id_load  = 1'b1;
                    id_instr = buf_q;
                    pc_d     = next_pc;
                    state_d  = ST_FETCH;
                end
            end
            default: begin
                id_squash = 1'b1;
                state_d   = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_WORD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
        .clk      (clk),
        .rst      (reset),
        .load_i   (id_load),
        .squash_i (id_squash),
        .hold_i   (id_hold),
        .pc_i     (pc_q),
        .instr_i  (id_instr),
        .pc_o     (pcID),
        .instr_o  (instrID),
        .vld_o    (validID)
    );

    // Request is held off while reset is high so it first rises after release.
    assign imem.imemReq  = (state_q == ST_FETCH) && !reset;
    assign imem.imemAddr = pc_q;
    assign pc            = pc_q;

    always_comb begin
        fetchValid  = 1'b0;
        instruction = NOP_WORD;
        if (state_q == ST_HOLD) begin
            fetchValid  = 1'b1;
            instruction = buf_q;
        end else if (state_q == ST_FETCH && ack && !reset) begin
            fetchValid  = 1'b1;
            instruction = imem.imemData;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] wait_cnt_q, squash_cnt_q;
    logic        wait_ev, squash_ev;

    assign wait_ev   = (state_q == ST_FETCH && !ack) || (state_q == ST_DROP);
    // In DROP the fetch is already squashed, so a further flush adds nothing.
    assign squash_ev = flushID && (state_q == ST_FETCH || state_q == ST_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (wait_ev && wait_cnt_q != 32'hFFFF_FFFF) wait_cnt_q <= wait_cnt_q + 32'd1;
            if (squash_ev && squash_cnt_q != 32'hFFFF_FFFF) squash_cnt_q <= squash_cnt_q + 32'd1;
        end
    end

    assign fetchWaitCount = wait_cnt_q;
    assign squashCount    = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency imem model, directed scenarios then
// random stall/flush/newPC traffic, scoreboard queues checked by two monitors.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] newPC;
    logic        flushID, flushEX, stall;
    logic [31:0] pc, instruction, pcID, instrID;
    logic        fetchValid, validID;
`ifdef FETCH_STATS_EN
    logic [31:0] fetchWaitCount, squashCount;
`endif

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .newPC       (newPC),
        .flushID     (flushID),
        .flushEX     (flushEX),
        .stall       (stall),
        .imem        (imem),
        .pc          (pc),
        .instruction (instruction),
        .fetchValid  (fetchValid),
        .pcID        (pcID),
        .instrID     (instrID),
        .validID     (validID)
`ifdef FETCH_STATS_EN
        ,
        .fetchWaitCount (fetchWaitCount),
        .squashCount    (squashCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic        fv;
        logic [31:0] ins;
    } if_exp_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] wait_cnt;
        logic [31:0] sq_cnt;
    } id_exp_t;

    if_exp_t q_if[$];
    id_exp_t q_id[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    // imem model state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          lat_mode;   // <0: random 0..3 cycles, else fixed latency

    // Reference model: architectural PC, stale-request flag, parked word, IF/ID.
    logic [31:0] m_pc, m_buf, m_idpc, m_idins, m_wait, m_squash;
    bit          m_stale, m_held, m_idv;

    task automatic model_reset();
        m_pc = RST_PC; m_buf = NOP; m_stale = 0; m_held = 0;
        m_idv = 0; m_idpc = 0; m_idins = NOP; m_wait = 0; m_squash = 0;
    endtask

    task automatic step(input bit st, input bit fl, input logic [31:0] npc);
        bit          ack;
        logic [31:0] dat, npcm;
        if_exp_t     e;
        id_exp_t     d;
        @(negedge clk);
        ack = 0;
        dat = 32'hDEAD_BEEF;
        if (mem_busy) mem_cnt--;
        else if (imem.imemReq === 1'b1) begin
            mem_busy = 1;
            mem_addr = imem.imemAddr;
            mem_cnt  = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
        end
        if (mem_busy && mem_cnt == 0) begin
            ack = 1; dat = mem_word(mem_addr); mem_busy = 0;
        end
        stall = st; flushID = fl; flushEX = 1'($urandom); newPC = npc;
        imem.imemAck = ack; imem.imemData = dat;

        e.req  = !m_stale && !m_held;
        e.addr = m_pc;
        e.pc   = m_pc;
        e.fv   = m_held || (e.req && ack);
        e.ins  = m_held ? m_buf : ((e.req && ack) ? mem_word(m_pc) : NOP);
        q_if.push_back(e);

        if (((e.req && !ack) || m_stale) && m_wait != 32'hFFFF_FFFF) m_wait++;
        if (fl && !m_stale && m_squash != 32'hFFFF_FFFF) m_squash++;

        npcm = npc & 32'hFFFF_FFFC;
        if (m_held) begin
            if (fl) begin
                m_pc = npcm; m_held = 0; m_idv = 0; m_idins = NOP;
            end else if (!st) begin
                m_idv = 1; m_idpc = m_pc; m_idins = m_buf; m_pc = npcm; m_held = 0;
            end
        end else if (m_stale) begin
            m_idv = 0; m_idins = NOP;
            if (ack) m_stale = 0;
            if (fl) m_pc = npcm;
        end else if (ack) begin
            if (fl) begin
                m_idv = 0; m_idins = NOP; m_pc = npcm;
            end else if (st) begin
                m_held = 1; m_buf = mem_word(m_pc);
            end else begin
                m_idv = 1; m_idpc = m_pc; m_idins = mem_word(m_pc); m_pc = npcm;
            end
        end else if (fl) begin
            m_pc = npcm; m_stale = 1; m_idv = 0; m_idins = NOP;
        end else if (!st) begin
            m_idv = 0; m_idins = NOP;
        end

        d.v = m_idv; d.pc = m_idpc; d.ins = m_idins; d.wait_cnt = m_wait; d.sq_cnt = m_squash;
        q_id.push_back(d);
    endtask

    // Reset pulse, optionally with a late ack from an abandoned request.
    task automatic do_reset(input bit late_ack);
        @(negedge clk);
        reset = 1; stall = 0; flushID = 0;
        imem.imemAck = late_ack; imem.imemData = 32'hBAD0_BAD0;
        @(negedge clk);
        imem.imemAck = 0;
        #1;
        chk("rst pc", pc, RST_PC);
        chk("rst imemReq", imem.imemReq, 0);
        chk("rst validID", validID, 0);
        chk("rst instrID", instrID, NOP);
        chk("rst pcID", pcID, 0);
`ifdef FETCH_STATS_EN
        chk("rst fetchWaitCount", fetchWaitCount, 0);
        chk("rst squashCount", squashCount, 0);
`endif
        mem_busy = 0;
        model_reset();
        reset = 0;
    endtask

    // Monitor for same-cycle IF outputs.
    initial begin
        if_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q_if.size() > 0) begin
                e = q_if.pop_front();
                chk("imemReq", imem.imemReq, e.req);
                if (e.req) chk("imemAddr", imem.imemAddr, e.addr);
                chk("pc", pc, e.pc);
                chk("fetchValid", fetchValid, e.fv);
                chk("instruction", instruction, e.ins);
            end
        end
    end

    // Monitor for the IF/ID register after each clock edge.
    initial begin
        id_exp_t d;
        forever begin
            @(posedge clk);
            #1;
            if (q_id.size() > 0) begin
                d = q_id.pop_front();
                chk("validID", validID, d.v);
                chk("instrID", instrID, d.ins);
                if (d.v) chk("pcID", pcID, d.pc);
`ifdef FETCH_STATS_EN
                chk("fetchWaitCount", fetchWaitCount, d.wait_cnt);
                chk("squashCount", squashCount, d.sq_cnt);
`endif
            end
        end
    end

    initial begin
        bit          st, fl;
        logic [31:0] npc;
        reset = 1; stall = 0; flushID = 0; flushEX = 0; newPC = 0;
        imem.imemAck = 0; imem.imemData = 0;
        mem_busy = 0; lat_mode = 0;
        model_reset();
        do_reset(0);

        // zero-wait sequential fetch: 0x3000, 0x3004, ... up to pc 0x3010
        for (int i = 0; i < 4; i++) step(0, 0, m_pc + 4);
        // 3-cycle ack at 0x3010
        lat_mode = 3;
        for (int i = 0; i < 4; i++) step(0, 0, m_pc + 4);
        // run to 0x3020, then flush to 0x3100 while it is pending
        lat_mode = 0;
        for (int i = 0; i < 3; i++) step(0, 0, m_pc + 4);
        lat_mode = 2;
        step(0, 0, m_pc + 4);
        step(0, 1, 32'h0000_3100);
        step(0, 0, 32'h0000_3100);
        lat_mode = 0;
        step(0, 0, m_pc + 4);
        step(0, 0, 32'h0000_3040);
        // ack at 0x3040 under a 4-cycle stall, then release
        for (int i = 0; i < 4; i++) step(1, 0, 32'h0000_3044);
        step(0, 0, 32'h0000_3044);
        // flush and stall together
        step(1, 1, 32'h0000_3200);
        step(0, 0, m_pc + 4);
        lat_mode = 1;
        step(1, 1, 32'h0000_3203);   // low bits masked on load
        step(0, 0, m_pc + 4);
        step(0, 0, m_pc + 4);
        // wrap at the top of the address space
        lat_mode = 0;
        step(0, 0, 32'hFFFF_FFFB);
        step(0, 0, m_pc + 4);
        step(0, 0, m_pc + 4);
        step(0, 0, m_pc + 4);

        // random traffic
        lat_mode = -1;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(3, 0) == 0);
            fl = ($urandom_range(6, 0) == 0);
            case ($urandom_range(9, 0))
                0:       npc = $urandom;
                1:       npc = 32'hFFFF_FFFC;
                default: npc = m_pc + 4;
            endcase
            step(st, fl, npc);
        end

        // reset while in DROP, with the stale ack arriving late
        lat_mode = 3;
        step(0, 0, m_pc + 4);
        step(0, 0, m_pc + 4);
        step(0, 1, 32'h0000_3300);
        do_reset(1);
        lat_mode = 0;
        for (int i = 0; i < 4; i++) step(0, 0, m_pc + 4);

        repeat (2) @(negedge clk);
        chk("scoreboard drained", q_if.size() + q_id.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
